// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants for the instruction-fetch front end.
// Holds the fetch FSM state encoding, the instruction width and the boot address.
package riscv_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES          = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  // Branch targets are forced onto a word boundary before use.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/ready channel plus the decode-side valid/ready slot.
// master = fetch sequencer, slave = memory/decode environment.
interface fetch_sequencer_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ready, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ready, imem_rdata, instr_ready
  );

endinterface

// File: rtl/fetch_slot.sv
// One-entry valid/ready holding register between fetch and decode.
// A load wins over everything; drop discards the entry but a same-cycle transfer still fires.
module fetch_slot (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  input  logic        drop,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_fire
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;

  assign out_fire = valid_q & out_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (load) begin
      valid_d = 1'b1;
      instr_d = load_instr;
      pc_d    = load_pc;
    end else if (drop || out_fire) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: the data registers are reset too, because instr/instr_pc are visible outputs with defined reset values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_pc    = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter owner: issues word fetches, parks each returned word in a one-entry
// slot for decode, and applies branch redirects including squashing an in-flight fetch.
module fetch_sequencer
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_addr,
  fetch_sequencer_if.master         bus,
  output logic                      misaligned,
  output logic [31:0]               fetch_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         squash_q, squash_d;
  logic [31:0]  target_q, target_d;
  logic [31:0]  count_q, count_d;

  logic         slot_load;
  logic         slot_drop;
  logic         slot_fire;
  logic [31:0]  redirect_target;

  assign redirect_target = align_word(redirect_addr);
  assign misaligned      = redirect_valid & (|redirect_addr[1:0]);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    squash_d  = squash_q;
    target_d  = target_q;
    slot_load = 1'b0;
    slot_drop = 1'b0;

    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
        pc_d    = redirect_valid ? redirect_target : RESET_VECTOR;
      end
      FETCH: begin
        if (bus.imem_ready) begin
          if (squash_q || redirect_valid) begin
            // Returned word belongs to the abandoned path; the newest target wins.
            pc_d     = redirect_valid ? redirect_target : target_q;
            squash_d = 1'b0;
          end else begin
            slot_load = 1'b1;
            pc_d      = pc_q + 32'(INSTR_BYTES);
            state_d   = HOLD;
          end
        end else if (redirect_valid) begin
          // Address must stay stable until the memory answers, so remember the target.
          squash_d = 1'b1;
          target_d = redirect_target;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          slot_drop = 1'b1;
          pc_d      = redirect_target;
          state_d   = FETCH;
        end else if (bus.instr_ready) begin
          state_d = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // The held word predates any branch, so a same-cycle transfer still counts.
  assign count_d = count_q + {31'd0, slot_fire};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= BOOT;
      pc_q     <= RESET_VECTOR;
      squash_q <= 1'b0;
      target_q <= RESET_VECTOR;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      squash_q <= squash_d;
      target_q <= target_d;
      count_q  <= count_d;
    end
  end

  fetch_slot u_slot (
    .clk        (clk),
    .reset      (reset),
    .load       (slot_load),
    .load_instr (bus.imem_rdata),
    .load_pc    (pc_q),
    .drop       (slot_drop),
    .out_ready  (bus.instr_ready),
    .out_valid  (bus.instr_valid),
    .out_instr  (bus.instr),
    .out_pc     (bus.instr_pc),
    .out_fire   (slot_fire)
  );

  assign bus.imem_req  = (state_q == FETCH);
  assign bus.imem_addr = pc_q;
  assign fetch_count   = count_q;

endmodule
